// File: rtl/alu_writeback_seq_pkg.sv
// Shared definitions for the ALU writeback sequencer: condition codes,
// NZCV bit positions and the sequencer state encoding.
package alu_writeback_seq_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [1:0] wb_state_t;
  localparam wb_state_t IDLE  = 2'd0;
  localparam wb_state_t WB_LO = 2'd1;
  localparam wb_state_t WB_HI = 2'd2;

endpackage

// File: rtl/alu_writeback_seq_cond_check.sv
// Combinational ARM condition decoder: cond field + NZCV -> execute flag.
// Shared with the branch logic, so it carries no state.
module cond_check
  import alu_writeback_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      // 4'b1111 behaves as AL
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_writeback_seq.sv
// ALU writeback sequencer: condition check, NZCV update and one/two beat
// register-file writes. Optional perf counters under WB_PERF_CNT_EN.
module alu_writeback_seq
  import alu_writeback_seq_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [DW-1:0] result_lo,
  input  logic [DW-1:0] result_hi,
  input  logic [3:0]    alu_flags,
  input  logic [3:0]    cond,
  input  logic [1:0]    flag_w,
  input  logic          reg_write,
  input  logic          is_long,
  input  logic [AW-1:0] rd_lo,
  input  logic [AW-1:0] rd_hi,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  input  logic          rf_ready,
  output logic [3:0]    flags,
  output logic          cond_ex,
  output logic          done
`ifdef WB_PERF_CNT_EN
  ,
  output logic [15:0]   exec_cnt,
  output logic [15:0]   squash_cnt
`endif
);

  wb_state_t     state;
  logic [DW-1:0] lo_q, hi_q;
  logic [AW-1:0] rd_lo_q, rd_hi_q;
  logic          long_q;
  logic          accept;

  cond_check u_cond_check (
    .cond    (cond),
    .nzcv    (flags),
    .cond_ex (cond_ex)
  );

  assign op_ready = (state == IDLE);
  assign accept   = op_valid && op_ready;

  // Control: state, architectural flags and the completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      flags <= 4'b0000;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cond_ex) begin
              if (flag_w[1]) begin
                flags[FLAG_N] <= alu_flags[FLAG_N];
                flags[FLAG_Z] <= alu_flags[FLAG_Z];
              end
              if (flag_w[0]) begin
                flags[FLAG_C] <= alu_flags[FLAG_C];
                flags[FLAG_V] <= alu_flags[FLAG_V];
              end
            end
            if (cond_ex && reg_write) state <= WB_LO;
            else                      done  <= 1'b1;
          end
        end
        WB_LO: begin
          if (rf_ready) begin
            if (long_q) begin
              state <= WB_HI;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        WB_HI: begin
          if (rf_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Captured operands; only executed operations overwrite them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q    <= '0;
      hi_q    <= '0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
      long_q  <= 1'b0;
    end else if (accept && cond_ex) begin
      lo_q    <= result_lo;
      hi_q    <= result_hi;
      rd_lo_q <= rd_lo;
      rd_hi_q <= rd_hi;
      long_q  <= is_long;
    end
  end

  // Write port driven purely from state so it holds steady across stalls
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    case (state)
      WB_LO: begin
        rf_we = 1'b1;
        rf_wa = rd_lo_q;
        rf_wd = lo_q;
      end
      WB_HI: begin
        rf_we = 1'b1;
        rf_wa = rd_hi_q;
        rf_wd = hi_q;
      end
      default: ;
    endcase
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt   <= 16'd0;
      squash_cnt <= 16'd0;
    end else if (accept) begin
      if (cond_ex) exec_cnt   <= exec_cnt + 16'd1;
      else         squash_cnt <= squash_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_writeback_seq.md
Name: alu_writeback_seq

Overview:
- Downstream consumer of the ALU in the multi-cycle datapath.
- Latches Result/ResultHi/ALUFlags and evaluates the instruction condition against the architectural NZCV register, then updates the flags.
- Sequences one or two register-file write beats: two beats for 64-bit SMUL/UMUL results (RdLo, then RdHi).
- Presents a valid/ready handshake toward the controller and a write-request/ready handshake toward the shared register-file write port.

Parameters:
- DW, 32, data width of Result/ResultHi and write data.
- AW, 4, register address width (16 architectural registers).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  controller presents an executed ALU operation.
- op_ready  out  1  block can accept an operation (high only in IDLE).
- result_lo  in  DW  ALU Result.
- result_hi  in  DW  ALU ResultHi.
- alu_flags  in  4  ALU flags, ordered {N,Z,C,V}.
- cond  in  4  ARM condition field.
- flag_w  in  2  flag write enables: [1] updates N,Z; [0] updates C,V.
- reg_write  in  1  operation writes the register file.
- is_long  in  1  64-bit result; two write beats.
- rd_lo  in  AW  destination register for the low word.
- rd_hi  in  AW  destination register for the high word.
- rf_we  out  1  write request to the register file.
- rf_wa  out  AW  write address.
- rf_wd  out  DW  write data.
- rf_ready  in  1  register file accepts the beat this cycle.
- flags  out  4  architectural NZCV register.
- cond_ex  out  1  condition result of the operation currently being accepted (combinational).
- done  out  1  one-cycle pulse when an operation completes, whether executed or squashed.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, flags=4'b0000, rf_we=0, rf_wa=0, rf_wd=0, done=0.
  - Captured data registers cleared; any write sequence in flight is abandoned with no further beats.
- cond_ex is decoded from the registered flags N,Z,C,V:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL = 1; 1111 is treated as AL.
- Accept occurs when op_valid && op_ready. On the accept edge, if cond_ex:
  - flag_w[1] loads flags[3:2] from alu_flags[3:2].
  - flag_w[0] loads flags[1:0] from alu_flags[1:0].
  - result_lo, result_hi, rd_lo, rd_hi and is_long are captured.
- States:
  - IDLE: op_ready=1, rf_we=0.
    - Accept with !cond_ex, or with cond_ex && !reg_write: stay in IDLE; done=1 next cycle. Flags are not updated when squashed.
    - Accept with cond_ex && reg_write: go to WB_LO.
  - WB_LO: rf_we=1, rf_wa=rd_lo, rf_wd=captured lo.
    - Holds until rf_ready. Then go to WB_HI if is_long; otherwise go to IDLE with done=1 next cycle.
  - WB_HI: rf_we=1, rf_wa=rd_hi, rf_wd=captured hi.
    - On rf_ready, go to IDLE with done=1 next cycle.
- Latency:
  - Squashed or no-write operation: done 1 cycle after accept.
  - Short write: earliest done 2 cycles after accept.
  - Long write: earliest done 3 cycles after accept.
- rf_we/rf_wa/rf_wd are stable while rf_ready=0. Stalls are unbounded.
- rd_lo==rd_hi on a long op: both beats are issued; the hi beat wins.
- Inputs are ignored outside IDLE. op_valid held high re-accepts only after the return to IDLE. Back-to-back ops: the next accept is the cycle done is high.
- The condition for op N+1 sees the flags updated by op N.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- When defined:
  - Adds outputs exec_cnt[15:0] and squash_cnt[15:0].
  - exec_cnt increments on accept with cond_ex; squash_cnt increments on accept with !cond_ex.
  - Both wrap at 16'hFFFF to 0 and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Condition-code localparams (COND_EQ..COND_AL).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - State encoding typedef (IDLE, WB_LO, WB_HI).
- One natural sub-module: cond_check, a purely combinational decoder from cond + NZCV to cond_ex. It is reused by the branch logic.

Test Plan:
- Flags=0000; accept cond=1110, flag_w=11, alu_flags=0100, reg_write=1, rd_lo=3, result_lo=32'h5, rf_ready=1.
  -> flags=0100; one beat with rf_wa=3, rf_wd=5; done 2 cycles after accept.
- Flags=0100 (Z); accept cond=0001 (NE), reg_write=1, flag_w=11.
  -> rf_we never asserted; flags stay 0100; done 1 cycle after accept.
- UMUL long op, rd_lo=4, rd_hi=5, lo=32'h0000_0001, hi=32'hFFFF_FFFF, rf_ready held 0 for 3 cycles.
  -> beat (4, 32'h1) stable through the stall, then beat (5, 32'hFFFF_FFFF); done 1 cycle after the second handshake.
- Sweep all 16 cond values × 16 flag values through cond_check.
  -> cond_ex matches the decode table; 1111 always 1.
- Assert reset while in WB_HI.
  -> rf_we=0 immediately; flags=0, state=IDLE, op_ready=1; no hi beat after reset release.
- WB_PERF_CNT_EN defined; exec_cnt preloaded to 16'hFFFF; one executed op plus two squashed ops.
  -> exec_cnt=0, squash_cnt=2.
